// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between execute and the byte-addressed data RAM.
// Accepts one request, checks it, sequences the registered RAM read, responds.
module lsu_mem_ctrl #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic [1:0]        resp_err,
   output logic [ADDR_W-1:0] ram_address,
   output logic [2:0]        ram_bytes,
   output logic [31:0]       ram_wbus,
   output logic              ram_write,
   output logic              ram_signed,
   input  logic [31:0]       ram_q
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2,
      ERR     = 2'd3
   } state_t;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_MIS   = 2'b01;
   localparam logic [1:0] ERR_FAULT = 2'b10;
   localparam logic [1:0] ERR_ILL   = 2'b11;

   localparam logic [2:0] SZ_NONE = 3'b000;
   localparam logic [2:0] SZ_B    = 3'b001;
   localparam logic [2:0] SZ_H    = 3'b010;
   localparam logic [2:0] SZ_W    = 3'b100;

   state_t state_q, state_d;
   logic   wr_q, wr_d;
   logic [1:0] err_q, err_d;

   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic [1:0]        resp_err_q, resp_err_d;
   logic [ADDR_W-1:0] ram_address_q, ram_address_d;
   logic [2:0]        ram_bytes_q, ram_bytes_d;
   logic [31:0]       ram_wbus_q, ram_wbus_d;
   logic              ram_write_q, ram_write_d;
   logic              ram_signed_q, ram_signed_d;

   logic       dec_legal;
   logic [2:0] dec_bytes;
   logic       dec_signed;
   logic       chk_fault;
   logic       chk_mis;
   logic [1:0] chk_code;
   logic       accept;

   // Ready is withheld while reset is asserted so nothing can be taken then.
   assign req_ready = (state_q == IDLE) && rst_n;
   assign accept    = req_valid && req_ready;

   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_err    = resp_err_q;
   assign ram_address = ram_address_q;
   assign ram_bytes   = ram_bytes_q;
   assign ram_wbus    = ram_wbus_q;
   assign ram_write   = ram_write_q;
   assign ram_signed  = ram_signed_q;

   // Decode funct3 into RAM size/sign controls for the request direction.
   always_comb begin
      dec_legal  = 1'b1;
      dec_bytes  = SZ_NONE;
      dec_signed = 1'b0;
      if (req_write) begin
         case (req_funct3)
            3'b000:  dec_bytes = SZ_B;
            3'b001:  dec_bytes = SZ_H;
            3'b010:  dec_bytes = SZ_W;
            default: dec_legal = 1'b0;
         endcase
      end else begin
         case (req_funct3)
            3'b000: begin
               dec_bytes  = SZ_B;
               dec_signed = 1'b1;
            end
            3'b001: begin
               dec_bytes  = SZ_H;
               dec_signed = 1'b1;
            end
            3'b010:  dec_bytes = SZ_W;
            3'b100:  dec_bytes = SZ_B;
            3'b101:  dec_bytes = SZ_H;
            default: dec_legal = 1'b0;
         endcase
      end
   end

   // Request checks, reported with illegal > fault > misaligned priority.
   always_comb begin
      chk_fault = (req_addr >> ADDR_W) != 32'd0;
      chk_mis   = ((dec_bytes == SZ_H) && req_addr[0])
               || ((dec_bytes == SZ_W) && (req_addr[1:0] != 2'b00));
      if (!dec_legal) begin
         chk_code = ERR_ILL;
      end else if (chk_fault) begin
         chk_code = ERR_FAULT;
      end else if (chk_mis) begin
         chk_code = ERR_MIS;
      end else begin
         chk_code = ERR_OK;
      end
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_d       = state_q;
      wr_d          = wr_q;
      err_d         = err_q;
      resp_valid_d  = 1'b0;
      resp_rdata_d  = resp_rdata_q;
      resp_err_d    = resp_err_q;
      ram_address_d = '0;
      ram_bytes_d   = SZ_NONE;
      ram_wbus_d    = 32'd0;
      ram_write_d   = 1'b0;
      ram_signed_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               wr_d  = req_write;
               err_d = chk_code;
               if (chk_code != ERR_OK) begin
                  state_d = ERR;
               end else begin
                  state_d       = ACCESS;
                  ram_address_d = req_addr[ADDR_W-1:0];
                  ram_bytes_d   = dec_bytes;
                  ram_signed_d  = dec_signed;
                  ram_wbus_d    = req_wdata;
                  ram_write_d   = req_write;
               end
            end
         end
         ACCESS: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            resp_valid_d = 1'b1;
            resp_err_d   = ERR_OK;
            resp_rdata_d = wr_q ? 32'd0 : ram_q;
            state_d      = IDLE;
         end
         ERR: begin
            resp_valid_d = 1'b1;
            resp_err_d   = err_q;
            resp_rdata_d = 32'd0;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Controller state and per-transaction context.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         err_q   <= ERR_OK;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
      end
   end

   // Registered response and RAM-side outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_q  <= 1'b0;
         resp_rdata_q  <= 32'd0;
         resp_err_q    <= ERR_OK;
         ram_address_q <= '0;
         ram_bytes_q   <= SZ_NONE;
         ram_wbus_q    <= 32'd0;
         ram_write_q   <= 1'b0;
         ram_signed_q  <= 1'b0;
      end else begin
         resp_valid_q  <= resp_valid_d;
         resp_rdata_q  <= resp_rdata_d;
         resp_err_q    <= resp_err_d;
         ram_address_q <= ram_address_d;
         ram_bytes_q   <= ram_bytes_d;
         ram_wbus_q    <= ram_wbus_d;
         ram_write_q   <= ram_write_d;
         ram_signed_q  <= ram_signed_d;
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: behavioural RAM, shadow-memory reference model,
// directed scenarios plus randomized transactions.
module tb_lsu_mem_ctrl;

   localparam int AW = 8;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic [1:0]    resp_err;
   logic [AW-1:0] ram_address;
   logic [2:0]    ram_bytes;
   logic [31:0]   ram_wbus;
   logic          ram_write;
   logic          ram_signed;
   logic [31:0]   ram_q;

   int n_tests = 0;
   int n_fail  = 0;

   lsu_mem_ctrl #(.ADDR_W(AW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .ram_address (ram_address),
      .ram_bytes   (ram_bytes),
      .ram_wbus    (ram_wbus),
      .ram_write   (ram_write),
      .ram_signed  (ram_signed),
      .ram_q       (ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM honouring the bytes_/signed_/write_ contract.
   logic [7:0] ram_mem [0:255];
   bit ram_inited = 1'b0;
   always @(posedge clk) begin
      int n;
      logic [31:0] v;
      if (!ram_inited) begin
         for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
         ram_inited = 1'b1;
      end
      if (ram_bytes != 3'b000) begin
         n = ram_bytes[2] ? 4 : (ram_bytes[1] ? 2 : 1);
         if (ram_write) begin
            for (int i = 0; i < n; i++)
               ram_mem[ram_address + 8'(i)] = ram_wbus[8*i +: 8];
         end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++)
               v[8*i +: 8] = ram_mem[ram_address + 8'(i)];
            if (ram_signed && v[8*n-1])
               for (int j = 8*n; j < 32; j++) v[j] = 1'b1;
            ram_q <= v;
         end
      end
   end

   // Activity monitor, sampled on the falling edge.
   int          wr_pulses   = 0;
   int          busy_cycles = 0;
   int          resp_pulses = 0;
   logic [2:0]  mon_bytes;
   logic        mon_signed;
   logic [7:0]  mon_addr;
   logic [31:0] mon_wbus;
   always @(negedge clk) begin
      if (ram_write) wr_pulses++;
      if (resp_valid) resp_pulses++;
      if (ram_bytes != 3'b000) begin
         busy_cycles++;
         mon_bytes  = ram_bytes;
         mon_signed = ram_signed;
         mon_addr   = ram_address;
         mon_wbus   = ram_wbus;
      end
   end

   // Reference: shadow memory plus funct3 rules in plain arithmetic.
   logic [7:0]  shadow [0:255];
   logic [31:0] last_r;
   logic [1:0]  last_e;

   task automatic model(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [1:0] e, output logic [31:0] r,
                        output int sz, output bit sgn);
      bit legal;
      longint v;
      legal = 1'b1;
      sz    = 0;
      sgn   = 1'b0;
      r     = 32'd0;
      v     = 0;
      if (w) begin
         case (f3)
            3'd0: sz = 1;
            3'd1: sz = 2;
            3'd2: sz = 4;
            default: legal = 1'b0;
         endcase
      end else begin
         case (f3)
            3'd0: begin sz = 1; sgn = 1'b1; end
            3'd1: begin sz = 2; sgn = 1'b1; end
            3'd2: sz = 4;
            3'd4: sz = 1;
            3'd5: sz = 2;
            default: legal = 1'b0;
         endcase
      end
      if (!legal) begin
         e = 2'd3;
      end else if (a >= 32'd256) begin
         e = 2'd2;
      end else if ((a % sz) != 0) begin
         e = 2'd1;
      end else begin
         e = 2'd0;
         if (w) begin
            for (int i = 0; i < sz; i++)
               shadow[a + i] = 8'(d >> (8*i));
         end else begin
            for (int i = 0; i < sz; i++)
               v += longint'(shadow[a + i]) << (8*i);
            if (sgn && v >= (longint'(1) << (8*sz - 1)))
               v -= longint'(1) << (8*sz);
            r = v[31:0];
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // One transaction from the current (falling-edge) slot to its response.
   task automatic xact(input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input string name);
      logic [1:0]  e_exp;
      logic [31:0] r_exp;
      int sz;
      bit sgn;
      int lat;
      int want_lat;
      int w0;
      int b0;
      bit got;
      bit ok;
      model(w, f3, a, d, e_exp, r_exp, sz, sgn);
      ok = (e_exp == 2'd0);
      w0 = wr_pulses;
      b0 = busy_cycles;
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready: got %b want 1", name, req_ready);
      end
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = d;
      tick();
      req_valid  = 1'b0;
      req_write  = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      lat = 1;
      got = 1'b0;
      while (!got && lat <= 12) begin
         if (resp_valid === 1'b1) begin
            got = 1'b1;
         end else begin
            tick();
            lat++;
         end
      end
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL %s timeout: no resp_valid within %0d cycles", name, lat);
         return;
      end
      want_lat = ok ? 3 : 2;
      n_tests++;
      if (lat != want_lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, want_lat);
      end
      n_tests++;
      if (resp_err !== e_exp) begin
         n_fail++;
         $display("FAIL %s err: got %b want %b", name, resp_err, e_exp);
      end
      n_tests++;
      if (resp_rdata !== r_exp) begin
         n_fail++;
         $display("FAIL %s rdata: got %h want %h", name, resp_rdata, r_exp);
      end
      n_tests++;
      if ((wr_pulses - w0) != ((w && ok) ? 1 : 0)) begin
         n_fail++;
         $display("FAIL %s ram_write pulses: got %0d want %0d",
                  name, wr_pulses - w0, (w && ok) ? 1 : 0);
      end
      n_tests++;
      if ((busy_cycles - b0) != (ok ? 1 : 0)) begin
         n_fail++;
         $display("FAIL %s ram busy cycles: got %0d want %0d",
                  name, busy_cycles - b0, ok ? 1 : 0);
      end
      if (ok) begin
         n_tests++;
         if (mon_bytes !== 3'(sz) || mon_signed !== sgn
             || mon_addr !== a[7:0]) begin
            n_fail++;
            $display("FAIL %s ram ctl: got b%b s%b a%h want b%b s%b a%h",
                     name, mon_bytes, mon_signed, mon_addr,
                     3'(sz), sgn, a[7:0]);
         end
         n_tests++;
         if (mon_wbus !== d) begin
            n_fail++;
            $display("FAIL %s ram_wbus: got %h want %h", name, mon_wbus, d);
         end
      end
      last_r = r_exp;
      last_e = e_exp;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      tick();
      tick();
      n_tests++;
      if ({resp_valid, resp_rdata, resp_err} !== 35'd0) begin
         n_fail++;
         $display("FAIL reset resp: got v%b r%h e%b want 0",
                  resp_valid, resp_rdata, resp_err);
      end
      n_tests++;
      if ({ram_address, ram_bytes, ram_wbus, ram_write, ram_signed} !== '0) begin
         n_fail++;
         $display("FAIL reset ram: got a%h b%b w%h we%b s%b want 0",
                  ram_address, ram_bytes, ram_wbus, ram_write, ram_signed);
      end
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_word();
      xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw_10");
      tick();
      xact(1'b0, 3'b010, 32'h10, 32'h0, "lw_10");
   endtask

   task automatic test_hold();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (resp_valid !== 1'b0 || resp_rdata !== last_r
             || resp_err !== last_e) begin
            n_fail++;
            $display("FAIL hold: got v%b r%h e%b want v0 r%h e%b",
                     resp_valid, resp_rdata, resp_err, last_r, last_e);
         end
      end
   endtask

   task automatic test_back_to_back();
      tick();
      xact(1'b1, 3'b000, 32'h20, 32'hABCDEF80, "sb_20");
      tick();
      xact(1'b0, 3'b000, 32'h20, 32'h0, "lb_20");
      xact(1'b0, 3'b100, 32'h20, 32'h0, "lbu_20");
   endtask

   task automatic test_half();
      tick();
      xact(1'b1, 3'b001, 32'h30, 32'h12348001, "sh_30");
      xact(1'b0, 3'b001, 32'h30, 32'h0, "lh_30");
      xact(1'b0, 3'b101, 32'h30, 32'h0, "lhu_30");
   endtask

   task automatic test_errors();
      tick();
      xact(1'b0, 3'b010, 32'h12, 32'h0, "lw_mis");
      xact(1'b0, 3'b001, 32'h31, 32'h0, "lh_mis");
      xact(1'b1, 3'b010, 32'h100, 32'h55AA55AA, "sw_fault");
      xact(1'b0, 3'b010, 32'h102, 32'h0, "lw_fault_over_mis");
   endtask

   task automatic test_illegal();
      tick();
      xact(1'b0, 3'b011, 32'h40, 32'h0, "ld_f3_011");
      xact(1'b1, 3'b100, 32'h40, 32'hFFFFFFFF, "st_f3_100");
      xact(1'b0, 3'b110, 32'h101, 32'h0, "ld_ill_over_fault");
   endtask

   task automatic test_reset_mid();
      int rp0;
      tick();
      rp0 = resp_pulses;
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h10;
      req_wdata  = 32'h0;
      tick();
      req_valid = 1'b0;
      n_tests++;
      if (ram_bytes !== 3'b100) begin
         n_fail++;
         $display("FAIL mid access bytes: got %b want 100", ram_bytes);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({resp_valid, resp_rdata, resp_err, ram_address, ram_bytes,
           ram_wbus, ram_write, ram_signed} !== '0) begin
         n_fail++;
         $display("FAIL mid reset outputs: got v%b r%h e%b a%h b%b",
                  resp_valid, resp_rdata, resp_err, ram_address, ram_bytes);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      n_tests++;
      if (resp_pulses != rp0) begin
         n_fail++;
         $display("FAIL mid reset resp pulses: got %0d want 0",
                  resp_pulses - rp0);
      end
      xact(1'b0, 3'b010, 32'h10, 32'h0, "lw_after_reset");
   endtask

   task automatic test_random();
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      for (int k = 0; k < 120; k++) begin
         w  = 1'($urandom);
         f3 = 3'($urandom_range(0, 7));
         a  = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) a = a & ~32'(f3[1] ? 3 : f3[0]);
         if ($urandom_range(0, 9) == 0)
            a = a | (32'd1 << $urandom_range(8, 31));
         if ($urandom_range(0, 1) == 0) tick();
         xact(w, f3, a, $urandom, "random");
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
      last_r = 32'd0;
      last_e = 2'd0;
      test_reset();
      test_word();
      test_hold();
      test_back_to_back();
      test_half();
      test_errors();
      test_illegal();
      test_reset_mid();
      test_random();
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller between the execute stage and the byte-addressed data RAM.
- Accepts one memory request per transaction over a valid/ready handshake, then decodes RISC-V funct3 into the RAM's byte-count/sign controls.
- Rejects misaligned, out-of-range and illegal accesses before they reach the RAM.
- Sequences the RAM's one-cycle registered read and returns the result with a one-cycle response pulse, stalling the pipeline meanwhile.

Parameters:
- ADDR_W, 8, RAM address width; the RAM holds 2^ADDR_W bytes.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a request
- req_ready  out  1  controller can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_addr  in  32  effective byte address
- req_wdata  in  32  store data, low bytes used per size
- resp_valid  out  1  one-cycle pulse: transaction complete
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- resp_err  out  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct3
- ram_address  out  ADDR_W  to RAM address
- ram_bytes  out  3  to RAM bytes_ (001 byte, 010 half, 100 word, 000 idle)
- ram_wbus  out  32  to RAM write data
- ram_write  out  1  to RAM write_
- ram_signed  out  1  to RAM signed_
- ram_q  in  32  RAM registered read data, valid the cycle after the RAM samples a read

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=00.
  - All ram_* outputs are 0.
  - req_ready goes high once rst_n is released.
- All ram_* and resp_* outputs are registered.
- Outside ACCESS, ram_write=0 and ram_bytes=000.
- funct3 decode:
  - Loads: 000 LB (bytes 001, signed 1); 001 LH (010, 1); 010 LW (100, 0); 100 LBU (001, 0); 101 LHU (010, 0).
  - Stores: 000 SB (001); 001 SH (010); 010 SW (100); ram_signed=0.
  - Any other funct3 for the given direction is illegal.
- Check priority at accept: illegal funct3 (11), then access fault (10), then misaligned (01).
  - Access fault: req_addr[31:ADDR_W] != 0.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - An aligned access never wraps the RAM address.
- States:
  - IDLE: req_ready=1. On req_valid, latch address, funct3, write flag and wdata.
    - Request fails a check: go to ERR.
    - Otherwise: go to ACCESS.
  - ACCESS (1 cycle): drive ram_address=addr[ADDR_W-1:0], ram_bytes, ram_signed, ram_wbus=wdata, ram_write. Go to CAPTURE.
  - CAPTURE (1 cycle): ram_* idle.
    - Load: register ram_q into resp_rdata.
    - Store: resp_rdata=0.
    - Set resp_valid=1, resp_err=00 for the next cycle. Go to IDLE.
  - ERR (1 cycle): no RAM access. Set resp_valid=1, resp_err=code, resp_rdata=0 for the next cycle. Go to IDLE.
- Latency (accept edge to resp_valid high):
  - Good access: 3 cycles.
  - Rejected request: 2 cycles.
- resp_valid is high exactly one cycle.
- A new request may be accepted in the same cycle resp_valid is high (back-to-back). Sustained throughput is one transaction per 3 cycles.
- resp_rdata/resp_err hold their value until the next response. resp_valid alone qualifies them.
- ram_write is high for exactly one cycle per good store and never for a rejected request.
- req_valid while req_ready=0 is ignored. There is no request buffering; the upstream stage holds its request.
- Reset asserted mid-transaction: state returns to IDLE and resp_valid is dropped. A store already issued in ACCESS may complete in the RAM; no other write occurs.

Test Plan:
- All scenarios use a behavioural RAM model implementing the bytes_/signed_/write_ contract above.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> ram_write pulsed once; LW resp_valid 3 cycles after accept; resp_rdata=0xDEADBEEF, resp_err=00.
- SB 0x20=0x80, then LB 0x20 and LBU 0x20 back-to-back -> resp_rdata 0xFFFFFF80 then 0x00000080; second request accepted in the cycle of the first resp_valid.
- SH 0x30=0x8001, then LH 0x30 and LHU 0x30 -> 0xFFFF8001 and 0x00008001.
- LW 0x12, LH 0x31, and SW 0x100 (ADDR_W=8) -> resp_err 01, 01, 10; resp_valid 2 cycles after accept; ram_bytes stays 000 throughout.
- Load funct3=011, then store funct3=100 -> resp_err=11, resp_rdata=0, no RAM activity.
- Pull rst_n low during ACCESS of a LW -> all outputs 0 immediately, no resp_valid. After release, req_ready=1 and a fresh LW completes normally.
